// File: rtl/sequence_checker_pkg.sv
// Shared definitions for the sequence checker and its benches:
// state enum, default data width and the numeric state encodings.
package seq_pkg;

  localparam int DATA_W_DEFAULT = 8;

  // Numeric encodings as they appear on the state output port
  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    SYNC   = ST_SYNC,
    LOCKED = ST_LOCKED
  } seq_state_e;

endpackage

// File: rtl/sequence_checker_sat_counter.sv
// Parameterised-width saturating up-counter. Clear has priority over
// increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up on inc, hold at all-ones, clear on clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (clr)                 r_cnt <= '0;
    else if (inc && r_cnt != '1)  r_cnt <= r_cnt + W'(1);
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sequence_checker.sv
// Sequence checker: tracks a stream that should advance by STEP on every
// valid sample, locks after LOCK_COUNT consecutive hits and drops lock after
// LOSS_COUNT consecutive misses. All outputs are registered.
// Optional build macro SEQ_CHECKER_ERR_CNT_EN enables the saturating error
// counter; without it err_cnt is tied to zero.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        state,
  output logic              locked,
  output logic              mismatch,
  output logic [DATA_W-1:0] expected,
  output logic [ERR_W-1:0]  err_cnt
);

  // Match/miss counters only need to reach 15
  localparam int CNT_W = 4;
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);
  localparam logic [CNT_W:0]    LOCK_V = (CNT_W+1)'(LOCK_COUNT);
  localparam logic [CNT_W:0]    LOSS_V = (CNT_W+1)'(LOSS_COUNT);

  seq_state_e        r_state, w_nxt_state;
  logic [DATA_W-1:0] r_expected, w_nxt_expected;
  logic              r_locked, r_mismatch, w_nxt_mismatch;
  logic              w_match_inc, w_match_clr, w_miss_inc, w_miss_clr;
  logic [CNT_W-1:0]  w_match_cnt, w_miss_cnt;
  logic              w_hit, w_match_last, w_miss_last;

  assign w_hit        = (data == r_expected);
  // "This hit/miss is the one that reaches the threshold"
  assign w_match_last = ({1'b0, w_match_cnt} + (CNT_W+1)'(1)) == LOCK_V;
  assign w_miss_last  = ({1'b0, w_miss_cnt}  + (CNT_W+1)'(1)) == LOSS_V;

  sat_counter #(.W(CNT_W)) u_match (
    .clk(clk), .rst(rst), .inc(w_match_inc), .clr(w_match_clr), .cnt(w_match_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss (
    .clk(clk), .rst(rst), .inc(w_miss_inc), .clr(w_miss_clr), .cnt(w_miss_cnt)
  );

  // Next-state, prediction update and counter control; idle when enable=0
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_expected = r_expected;
    w_nxt_mismatch = 1'b0;
    w_match_inc    = 1'b0;
    w_match_clr    = 1'b0;
    w_miss_inc     = 1'b0;
    w_miss_clr     = 1'b0;
    if (enable) begin
      case (r_state)
        HUNT: begin
          w_nxt_expected = data + STEP_V;
          w_match_clr    = 1'b1;
          w_nxt_state    = SYNC;
        end
        SYNC: begin
          if (w_hit) begin
            w_match_inc    = 1'b1;
            w_nxt_expected = r_expected + STEP_V;
            if (w_match_last) begin
              w_nxt_state = LOCKED;
              w_miss_clr  = 1'b1;
            end
          end else begin
            // Reseed from the observed value, no error reported
            w_nxt_expected = data + STEP_V;
            w_match_clr    = 1'b1;
          end
        end
        LOCKED: begin
          // Prediction free-runs whether or not the sample matched
          w_nxt_expected = r_expected + STEP_V;
          if (w_hit) begin
            w_miss_clr = 1'b1;
          end else begin
            w_nxt_mismatch = 1'b1;
            w_miss_inc     = 1'b1;
            if (w_miss_last) w_nxt_state = HUNT;
          end
        end
        default: w_nxt_state = HUNT;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_expected <= '0;
      r_mismatch <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_expected <= w_nxt_expected;
      r_mismatch <= w_nxt_mismatch;
      r_locked   <= (w_nxt_state == LOCKED);
    end
  end

`ifdef SEQ_CHECKER_ERR_CNT_EN
  logic [ERR_W-1:0] w_err_cnt;

  // Every locked mismatch is an error; only reset clears the total
  sat_counter #(.W(ERR_W)) u_err (
    .clk(clk), .rst(rst), .inc(w_nxt_mismatch), .clr(1'b0), .cnt(w_err_cnt)
  );

  assign err_cnt = w_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign state    = r_state;
  assign locked   = r_locked;
  assign mismatch = r_mismatch;
  assign expected = r_expected;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed plus randomized bench for sequence_checker. A small
// behavioural model, stated in terms of the stream rules, predicts every
// output after each cycle.
module tb_sequence_checker;

  localparam int DW   = 8;
  localparam int STP  = 1;
  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int EW   = 16;

  logic          clk, rst, enable;
  logic [DW-1:0] data;
  logic [1:0]    state;
  logic          locked, mismatch;
  logic [DW-1:0] expected;
  logic [EW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  // Model: phase 0=hunt 1=sync 2=locked, plain integers throughout
  int m_phase, m_exp, m_run, m_bad, m_err, m_pulse;

  sequence_checker #(
    .DATA_W(DW), .STEP(STP), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .data(data),
    .state(state), .locked(locked), .mismatch(mismatch),
    .expected(expected), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0; m_exp = 0; m_run = 0; m_bad = 0; m_err = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit en, input int d);
    m_pulse = 0;
    if (!en) return;
    if (m_phase == 0) begin
      m_exp = (d + STP) % 256; m_run = 0; m_phase = 1;
    end else if (m_phase == 1) begin
      if (d == m_exp) begin
        m_run++; m_exp = (m_exp + STP) % 256;
        if (m_run == LOCK) begin m_phase = 2; m_bad = 0; end
      end else begin
        m_exp = (d + STP) % 256; m_run = 0;
      end
    end else begin
      if (d == m_exp) m_bad = 0;
      else begin
        m_pulse = 1; m_bad++;
        if (m_err < 65535) m_err++;
        if (m_bad == LOSS) m_phase = 0;
      end
      m_exp = (m_exp + STP) % 256;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    int e_err;
`ifdef SEQ_CHECKER_ERR_CNT_EN
    e_err = m_err;
`else
    e_err = 0;
`endif
    chk({tag, ".state"},    int'(state),    m_phase);
    chk({tag, ".locked"},   int'(locked),   int'(m_phase == 2));
    chk({tag, ".mismatch"}, int'(mismatch), m_pulse);
    chk({tag, ".expected"}, int'(expected), m_exp);
    chk({tag, ".err_cnt"},  int'(err_cnt),  e_err);
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge
  task automatic cyc(input bit en, input int d, input string tag);
    enable = en;
    data   = DW'(d);
    @(posedge clk);
    model_step(en, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data = '0;
    model_reset();
    #2;
    check_all("por");
    do_reset();

    // Lock acquisition from 0x10
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h10 + i, "lock");
    chk("lock.final_state", int'(state), 2);
    chk("lock.final_exp", int'(expected), 8'h15);

    // Wrap-around while locked
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hF9 + i, "wrap_lock");
    cyc(1'b1, 8'hFE, "wrap"); cyc(1'b1, 8'hFF, "wrap");
    cyc(1'b1, 8'h00, "wrap"); cyc(1'b1, 8'h01, "wrap");
    chk("wrap.exp", int'(expected), 8'h02);
    chk("wrap.locked", int'(locked), 1);

    // Single error, then loss of lock
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h1B + i, "err_lock");
    chk("err.exp20", int'(expected), 8'h20);
    cyc(1'b1, 8'h55, "err_bad");
    chk("err.pulse", int'(mismatch), 1);
    cyc(1'b1, 8'h21, "err_good");
    chk("err.still_locked", int'(locked), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hAA, "loss");
    chk("loss.state", int'(state), 0);

    // Enable gap while locked: nothing moves
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h70 + i, "gap_lock");
    for (int i = 0; i < 10; i++) cyc(1'b0, int'($urandom_range(0, 255)), "gap");
    chk("gap.exp", int'(expected), 8'h75);
    cyc(1'b1, 8'h75, "gap_resume");

    // SYNC reseed
    do_reset();
    cyc(1'b1, 8'h30, "sync_enter");
    chk("sync.exp31", int'(expected), 8'h31);
    cyc(1'b1, 8'h40, "reseed");
    chk("reseed.exp", int'(expected), 8'h41);
    chk("reseed.state", int'(state), 1);

    // Asynchronous reset mid-lock with five accumulated errors
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + i, "mid_lock");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, m_exp ^ 8'h80, "mid_bad");
      cyc(1'b1, m_exp, "mid_good");
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, i, "relock");
    chk("relock.state", int'(state), 2);

    // Randomized stream: mostly predicted values, some corruption and gaps
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit en;
      int d;
      en = ($urandom_range(0, 9) != 0);
      d  = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 255));
      cyc(en, d, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
